// File: rtl/ddf_pick_nflux.sv
// ddf_pick_nflux: dynamic-dataflow PICK actor with FLUX input channels.
// Pops one control token, then forwards a burst of LEN+1 data tokens from
// the selected channel through a one-entry output register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a control token; pops it when the NDA FIFO is non-empty
//   RUN   | moving the burst from channel sel, cnt tokens left after the next take
module ddf_pick_nflux #(
  parameter int WIDTH     = 8,
  parameter int FLUX      = 4,
  parameter int SEL_W     = 2,
  parameter int LEN_W     = 4,
  parameter int WIDTH_NDA = 8
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  nda_empty,
  output logic                  nda_read,
  input  logic [WIDTH_NDA-1:0]  nda_data,
  input  logic [FLUX-1:0]       in_empty,
  output logic [FLUX-1:0]       in_read,
  input  logic [FLUX*WIDTH-1:0] in_data,
  input  logic                  full,
  output logic                  wr,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // FLUX fits in SEL_W+1 bits because SEL_W >= clog2(FLUX).
  localparam logic [SEL_W:0] FLUX_LIM = FLUX[SEL_W:0];

  state_t            state, state_nx;
  logic [SEL_W-1:0]  sel, sel_nx;
  logic [LEN_W-1:0]  cnt, cnt_nx;
  logic              ov, ov_nx;
  logic [WIDTH-1:0]  od, od_nx;
  logic              err_q, err_nx;
  logic              busy_q, busy_nx;

  logic [SEL_W-1:0]  tok_sel;
  logic [LEN_W-1:0]  tok_len;
  logic              tok_ok;
  logic              ch_empty;
  logic [WIDTH-1:0]  ch_data;
  logic              take;

  // control token fields; bits above the LEN field carry no meaning here
  assign tok_sel = nda_data[SEL_W-1:0];
  assign tok_len = nda_data[SEL_W+LEN_W-1:SEL_W];
  assign tok_ok  = ({1'b0, tok_sel} < FLUX_LIM);

  generate
    if (WIDTH_NDA > SEL_W + LEN_W) begin : g_nda_spare
      logic unused_nda_bits;
      assign unused_nda_bits = ^nda_data[WIDTH_NDA-1:SEL_W+LEN_W];
    end
  endgenerate

  // head-of-channel mux; an index without a channel reads as an empty FIFO
  always_comb begin
    ch_empty = 1'b1;
    ch_data  = '0;
    for (int k = 0; k < FLUX; k++) begin
      if (sel == k[SEL_W-1:0]) begin
        ch_empty = in_empty[k];
        ch_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // output stage handshake and burst take condition
  always_comb begin
    wr       = ov & ~full;
    take     = (state == RUN) & ~ch_empty & (~ov | wr);
    // rst gating keeps the control FIFO untouched while reset is held
    nda_read = rst & (state == IDLE) & ~nda_empty;
  end

  // one-hot pop towards the selected channel
  always_comb begin
    in_read = '0;
    for (int k = 0; k < FLUX; k++) begin
      if (take && (sel == k[SEL_W-1:0])) begin
        in_read[k] = 1'b1;
      end
    end
  end

  // next-state logic for the burst FSM
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (nda_read) begin
          sel_nx = tok_sel;
          cnt_nx = tok_len;
          if (tok_ok) begin
            state_nx = RUN;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (take) begin
          if (cnt == '0) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - LEN_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // output register; a take always refills it, otherwise a write drains it
  always_comb begin
    ov_nx = ov;
    od_nx = od;
    if (take) begin
      ov_nx = 1'b1;
      od_nx = ch_data;
    end else if (wr) begin
      ov_nx = 1'b0;
    end
  end

  // busy is registered from the values the flops are about to take
  always_comb begin
    busy_nx = (state_nx != IDLE) | ov_nx;
  end

  // FSM and burst bookkeeping registers
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

  // output register and busy flag
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ov     <= 1'b0;
      od     <= '0;
      busy_q <= 1'b0;
    end else begin
      ov     <= ov_nx;
      od     <= od_nx;
      busy_q <= busy_nx;
    end
  end

  assign out_data = od;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
